// File: rtl/sram_ctrl.sv
// Sequencer turning ISDU level strobes (Mem_OE/Mem_WE) into timed async-SRAM
// read/write cycles with WAIT_CYCLES wait states and a one-cycle Ready pulse.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Busy,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data_Mem,
    output logic        CE_n,
    output logic        UB_n,
    output logic        LB_n,
    output logic        OE_n,
    output logic        WE_n
);

    typedef enum logic [2:0] {
        IDLE, READ, RD_DONE, WR_SETUP, WRITE, WR_HOLD, RECOVER
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] wdata_q, wdata_d;
    logic        drive_bus;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Write data is only observable while the bus is driven, so it needs no reset.
    always_ff @(posedge Clk) begin
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (Mem_WE) begin
                    state_d = WR_SETUP;
                    addr_d  = MAR;
                    wdata_d = Data_from_CPU;
                end else if (Mem_OE) begin
                    state_d = READ;
                    addr_d  = MAR;
                    cnt_d   = 4'd0;
                end
            end
            READ: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    rdata_d = Data_Mem;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_DONE:  state_d = Mem_OE ? RECOVER : IDLE;
            WR_SETUP: begin
                state_d = WRITE;
                cnt_d   = 4'd0;
            end
            WRITE: begin
                if (cnt_q == LAST_CNT) state_d = WR_HOLD;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            WR_HOLD:  state_d = Mem_WE ? RECOVER : IDLE;
            RECOVER: begin
                // Hold off until the request is withdrawn so one assertion = one access.
                if (!Mem_OE && !Mem_WE) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        CE_n      = 1'b1;
        OE_n      = 1'b1;
        WE_n      = 1'b1;
        UB_n      = 1'b1;
        LB_n      = 1'b1;
        Ready     = 1'b0;
        drive_bus = 1'b0;
        case (state_q)
            READ: begin
                CE_n = 1'b0;
                OE_n = 1'b0;
                UB_n = 1'b0;
                LB_n = 1'b0;
            end
            RD_DONE: begin
                CE_n  = 1'b0;
                Ready = 1'b1;
            end
            WR_SETUP: begin
                CE_n      = 1'b0;
                UB_n      = 1'b0;
                LB_n      = 1'b0;
                drive_bus = 1'b1;
            end
            WRITE: begin
                CE_n      = 1'b0;
                WE_n      = 1'b0;
                UB_n      = 1'b0;
                LB_n      = 1'b0;
                drive_bus = 1'b1;
            end
            WR_HOLD: begin
                CE_n      = 1'b0;
                UB_n      = 1'b0;
                LB_n      = 1'b0;
                Ready     = 1'b1;
                drive_bus = 1'b1;
            end
            default: ;
        endcase
    end

    assign Data_Mem    = drive_bus ? wdata_q : 16'hzzzz;
    assign Busy        = (state_q != IDLE);
    assign ADDR        = {4'h0, addr_q};
    assign Data_to_CPU = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (WAIT_CYCLES=2) with a small async-SRAM model
// and a switchable bus keeper used to observe when the controller releases Data_Mem.
module tb_sram_ctrl;

    localparam logic [15:0] KEEP = 16'hC3A5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] MAR = 16'h0000;
    logic [15:0] Data_from_CPU = 16'h0000;
    logic [15:0] Data_to_CPU;
    logic        Ready, Busy;
    logic [19:0] ADDR;
    wire  [15:0] Data_Mem;
    logic        CE_n, UB_n, LB_n, OE_n, WE_n;

    logic [15:0] mem [0:255];
    logic        keep_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU),
        .Ready(Ready), .Busy(Busy), .ADDR(ADDR), .Data_Mem(Data_Mem),
        .CE_n(CE_n), .UB_n(UB_n), .LB_n(LB_n), .OE_n(OE_n), .WE_n(WE_n)
    );

    always #5 Clk = ~Clk;

    // SRAM model: drives on CE_n/OE_n low, stores on any clock with CE_n/WE_n low.
    assign Data_Mem = (!CE_n && !OE_n) ? mem[ADDR[7:0]] : (keep_en ? KEEP : 16'hzzzz);

    always @(posedge Clk) begin
        if (!Reset_n)            mem[8'h12] <= 16'hBEEF;
        else if (!CE_n && !WE_n) mem[ADDR[7:0]] <= Data_Mem;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        MAR    = addr;
        Mem_OE = 1'b1;
        tick();
        check({tag, "_oe1"}, 32'(OE_n), 32'd0);
        check({tag, "_addr"}, 32'(ADDR), {16'h0, addr});
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        MAR = 16'hFFFF;
        tick();
        check({tag, "_oe2"}, 32'(OE_n), 32'd0);
        check({tag, "_rdy_early"}, 32'(Ready), 32'd0);
        tick();
        check({tag, "_oe_off"}, 32'(OE_n), 32'd1);
        check({tag, "_rdy"}, 32'(Ready), 32'd1);
        check({tag, "_data"}, 32'(Data_to_CPU), 32'(exp));
        check({tag, "_addr_hold"}, 32'(ADDR), {16'h0, addr});
        Mem_OE = 1'b0;
        tick();
        check({tag, "_rdy_off"}, 32'(Ready), 32'd0);
        check({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int oe_low;
        int rdy_cnt;
        int rdy_twice;
        logic prev_rdy;

        // Reset held with both requests asserted
        Mem_OE  = 1'b1;
        Mem_WE  = 1'b1;
        keep_en = 1'b1;
        #2 Reset_n = 1'b0;
        repeat (4) tick();
        check("rst_ce", 32'(CE_n), 32'd1);
        check("rst_oe", 32'(OE_n), 32'd1);
        check("rst_we", 32'(WE_n), 32'd1);
        check("rst_ublb", 32'({UB_n, LB_n}), 32'd3);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", 32'(Data_to_CPU), 32'h0);
        check("rst_addr", 32'(ADDR), 32'h0);
        check("rst_bus", 32'(Data_Mem), 32'(KEEP));
        Mem_OE  = 1'b0;
        Mem_WE  = 1'b0;
        keep_en = 1'b0;
        Reset_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(Busy), 32'd0);

        // Plain read
        do_read("rd", 16'h0012, 16'hBEEF);

        // Write; request dropped after the first cycle must not abort it
        MAR           = 16'h0040;
        Data_from_CPU = 16'h1234;
        Mem_WE        = 1'b1;
        tick();
        check("wr_setup_we", 32'(WE_n), 32'd1);
        check("wr_setup_ce", 32'(CE_n), 32'd0);
        check("wr_setup_bus", 32'(Data_Mem), 32'h1234);
        Mem_WE        = 1'b0;
        MAR           = 16'h0077;
        Data_from_CPU = 16'h0000;
        tick();
        check("wr_we1", 32'(WE_n), 32'd0);
        check("wr_bus1", 32'(Data_Mem), 32'h1234);
        tick();
        check("wr_we2", 32'(WE_n), 32'd0);
        check("wr_bus2", 32'(Data_Mem), 32'h1234);
        check("wr_rdy_early", 32'(Ready), 32'd0);
        tick();
        check("wr_hold_we", 32'(WE_n), 32'd1);
        check("wr_hold_bus", 32'(Data_Mem), 32'h1234);
        check("wr_hold_rdy", 32'(Ready), 32'd1);
        check("wr_hold_addr", 32'(ADDR), 32'h00040);
        tick();
        check("wr_rdy_off", 32'(Ready), 32'd0);
        check("wr_idle", 32'(Busy), 32'd0);
        do_read("rdback", 16'h0040, 16'h1234);

        // Simultaneous requests: write wins, then RECOVER until both drop
        MAR           = 16'h0041;
        Data_from_CPU = 16'hA55A;
        Mem_OE        = 1'b1;
        Mem_WE        = 1'b1;
        tick();
        check("both_setup_oe", 32'(OE_n), 32'd1);
        tick();
        check("both_we", 32'(WE_n), 32'd0);
        check("both_oe", 32'(OE_n), 32'd1);
        tick();
        tick();
        check("both_rdy", 32'(Ready), 32'd1);
        tick();
        check("both_recover_busy", 32'(Busy), 32'd1);
        check("both_recover_rdy", 32'(Ready), 32'd0);
        check("both_recover_strobes", 32'({CE_n, OE_n, WE_n, UB_n, LB_n}), 32'h1F);
        tick();
        check("both_recover_stay", 32'(Busy), 32'd1);
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        tick();
        check("both_idle", 32'(Busy), 32'd0);
        check("both_mem", 32'(mem[8'h41]), 32'hA55A);

        // Aborted read: one-cycle request
        MAR    = 16'h0012;
        Mem_OE = 1'b1;
        tick();
        check("abort_oe", 32'(OE_n), 32'd0);
        Mem_OE = 1'b0;
        tick();
        check("abort_idle", 32'(Busy), 32'd0);
        check("abort_rdy", 32'(Ready), 32'd0);
        tick();
        check("abort_rdy2", 32'(Ready), 32'd0);
        check("abort_data", 32'(Data_to_CPU), 32'h1234);

        // Request held for ten cycles yields one access
        Mem_OE    = 1'b1;
        oe_low    = 0;
        rdy_cnt   = 0;
        rdy_twice = 0;
        prev_rdy  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OE_n == 1'b0) oe_low++;
            if (Ready) rdy_cnt++;
            if (Ready && prev_rdy) rdy_twice++;
            prev_rdy = Ready;
        end
        check("hold_oe_cycles", 32'(oe_low), 32'd2);
        check("hold_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("hold_ready_twice", 32'(rdy_twice), 32'd0);
        check("hold_busy", 32'(Busy), 32'd1);
        Mem_OE = 1'b0;
        tick();
        check("hold_idle", 32'(Busy), 32'd0);
        check("hold_data", 32'(Data_to_CPU), 32'hBEEF);

        // Reset asserted during WRITE
        MAR           = 16'h0050;
        Data_from_CPU = 16'h0F0F;
        Mem_WE        = 1'b1;
        tick();
        tick();
        check("rstw_we_low", 32'(WE_n), 32'd0);
        Reset_n = 1'b0;
        Mem_WE  = 1'b0;
        #1;
        keep_en = 1'b1;
        #1;
        check("rstw_we", 32'(WE_n), 32'd1);
        check("rstw_ce", 32'(CE_n), 32'd1);
        check("rstw_busy", 32'(Busy), 32'd0);
        check("rstw_bus", 32'(Data_Mem), 32'(KEEP));
        tick();
        keep_en = 1'b0;
        Reset_n = 1'b1;
        tick();
        check("rstw_post_busy", 32'(Busy), 32'd0);
        do_read("rstw_rd", 16'h0012, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-access sequencer between the ISDU's level-style memory strobes (Mem_OE / Mem_WE) and the board's asynchronous 16-bit SRAM.

- Converts each request into a correctly timed SRAM read or write cycle with a parameterised number of wait states.
- Latches read data for the MDR and drives write data from the MDR.
- Reports completion with a one-cycle Ready pulse, so the control FSM need not hard-code memory wait states.

## Interface

Parameters:
- WAIT_CYCLES, default 2: cycles OE_n/WE_n are held low per access; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mem_OE  in  1  read request from ISDU, active-high level.
- Mem_WE  in  1  write request from ISDU, active-high level.
- MAR  in  16  word address.
- Data_from_CPU  in  16  write data (MDR contents).
- Data_to_CPU  out  16  registered read data, to the MDR input mux.
- Ready  out  1  one-cycle pulse: access complete.
- Busy  out  1  high whenever state ≠ IDLE.
- ADDR  out  20  SRAM address, {4'h0, latched MAR}.
- Data_Mem  inout  16  SRAM data bus.
- CE_n, UB_n, LB_n, OE_n, WE_n  out  1 each  SRAM strobes, active-low.

## Operation

- Moore FSM. Every output is decoded from the state register plus the address/data/count registers; no output depends combinationally on an input.
- States: IDLE, READ, RD_DONE, WR_SETUP, WRITE, WR_HOLD, RECOVER.
- IDLE:
  - Mem_WE=1 → WR_SETUP. Latch MAR and Data_from_CPU.
  - Else Mem_OE=1 → READ. Latch MAR.
  - Write has priority when both requests are high.
  - Wait counter clears on entry to READ or WRITE.
- READ:
  - CE_n=0, OE_n=0, UB_n=LB_n=0.
  - Counter increments each cycle. When count = WAIT_CYCLES-1, sample Data_Mem into Data_to_CPU → RD_DONE.
  - If Mem_OE drops while in READ → IDLE. Read is aborted, no Ready, Data_to_CPU unchanged.
- RD_DONE:
  - Ready=1, CE_n=0, OE_n=1.
  - Mem_OE still high → RECOVER; else → IDLE.
- WR_SETUP:
  - CE_n=0, WE_n=1, Data_Mem driven with latched data.
  - Always → WRITE after one cycle.
- WRITE:
  - WE_n=0, data driven.
  - Leaves when count = WAIT_CYCLES-1 → WR_HOLD.
  - Not abortable: dropping Mem_WE has no effect once the write has started.
- WR_HOLD:
  - WE_n=1, data still driven (hold time), Ready=1.
  - Mem_WE high → RECOVER; else → IDLE.
- RECOVER:
  - All strobes high.
  - Stays until Mem_OE=0 and Mem_WE=0, then → IDLE.
  - Guarantees exactly one access per request assertion.
- Data_Mem is driven only in WR_SETUP, WRITE and WR_HOLD; high-Z in all other states.
- Idle strobe values: CE_n=1, OE_n=1, WE_n=1, UB_n=1, LB_n=1.
- Counter width is 4 bits. Values above 15 are illegal and unsupported.

## Timing

- Reset (Reset_n=0, immediate, asynchronous):
  - State=IDLE, counter=0, latched address=0, Data_to_CPU=16'h0000.
  - Ready=0, Busy=0, ADDR=20'h0.
  - All strobes=1, Data_Mem=Z.
- Reset asserted mid-access aborts the access at once; the strobes go inactive without waiting for a clock.
- Let E0 be the edge that samples a request in IDLE.
- Read:
  - OE_n is low for exactly WAIT_CYCLES cycles after E0.
  - Data_to_CPU is valid, and Ready is high, during cycle WAIT_CYCLES+1 after E0.
  - Read latency: WAIT_CYCLES+1 cycles.
- Write:
  - WR_SETUP for 1 cycle, WE_n low for WAIT_CYCLES cycles, then WR_HOLD for 1 cycle.
  - Ready is high in cycle WAIT_CYCLES+2 after E0.
  - Write latency: WAIT_CYCLES+2 cycles.
- Address stability:
  - ADDR is stable from E0 until the state leaves RD_DONE or WR_HOLD.
  - A change on MAR during an access is ignored.
- Back-to-back:
  - A new request can start no earlier than the edge after the first IDLE cycle.
  - Minimum gap is one IDLE cycle.
- Ready is never high for two consecutive cycles.

## Test plan

1. Reset:
   - Stimulus: hold Reset_n=0 with Mem_OE=Mem_WE=1.
   - Required: all strobes 1, Ready=0, Busy=0, Data_to_CPU=0x0000, Data_Mem=Z. Outputs stay there for any number of clocks.
2. Read, WAIT_CYCLES=2:
   - Stimulus: SRAM model holds 0xBEEF at 0x00012; pulse Mem_OE with MAR=0x0012.
   - Required: OE_n low for 2 cycles, ADDR=0x00012, Ready high for 1 cycle at E0+3, Data_to_CPU=0xBEEF.
3. Write then readback:
   - Stimulus: Mem_WE with MAR=0x0040, Data_from_CPU=0x1234, then a read of 0x0040.
   - Required: WE_n low for exactly 2 cycles; Data_Mem=0x1234 in cycles E0+1..E0+4; Ready at E0+4; the readback returns 0x1234.
4. Simultaneous requests:
   - Stimulus: Mem_OE=Mem_WE=1 on the same edge.
   - Required: a write cycle occurs (WE_n pulses, OE_n stays 1), then RECOVER until both requests drop.
5. Abort and hold:
   - Stimulus A: Mem_OE high for 1 cycle only. Required: no Ready, Data_to_CPU unchanged.
   - Stimulus B: Mem_OE held high for 10 cycles. Required: exactly one OE_n pulse and one Ready.
6. Reset mid-write:
   - Stimulus: drop Reset_n during WRITE.
   - Required: WE_n=1 and Data_Mem=Z immediately (before the next edge). After release, Busy=0 and the FSM accepts a fresh read normally.
